// File: rtl/rd_ptr_sync_if.sv
// Read-side pointer/flag bundle of an async FIFO.
// slave = the read-pointer controller, master = the integrating read domain.
interface rd_ptr_sync_if #(
  parameter int ADDR_W = 10
);
  logic [ADDR_W:0]   wptr_g;
  logic              rinc;
  logic [ADDR_W-1:0] raddr;
  logic [ADDR_W:0]   rptr_g;
  logic [ADDR_W:0]   rq_wptr_b;
  logic [ADDR_W:0]   rcount;
  logic              rempty;
  logic              raempty;
  logic              rundf;

  modport slave (
    input  wptr_g, rinc,
    output raddr, rptr_g, rq_wptr_b, rcount, rempty, raempty, rundf
  );

  modport master (
    output wptr_g, rinc,
    input  raddr, rptr_g, rq_wptr_b, rcount, rempty, raempty, rundf
  );
endinterface

// File: rtl/rd_ptr_sync_ctrl.sv
// Async-FIFO read-side controller: write-pointer synchronizer, binary/Gray read
// pointer, registered empty / almost-empty / fill-level flags, sticky underflow.
module rd_ptr_sync_ctrl #(
  parameter int ADDR_W      = 10,
  parameter int SYNC_STAGES = 2,   // 2..4
  parameter int AEMPTY_TH   = 4
) (
  input  logic         rclk,
  input  logic         rrst_n,
  rd_ptr_sync_if.slave rif
);
  localparam int PW = ADDR_W + 1;
  localparam logic [PW-1:0] AE_TH = PW'(AEMPTY_TH);

  // Plain flop chain; wptr_g is Gray so only one bit can be in flight per step.
  logic [SYNC_STAGES-1:0][PW-1:0] sync_q;
  logic [PW-1:0] wq_g;
  logic [PW-1:0] wq_b;

  logic [PW-1:0] rbin, rbin_next;
  logic [PW-1:0] rgray, rgray_next;
  logic [PW-1:0] cnt_next;
  logic [PW-1:0] rcount_q;
  logic          rempty_q, raempty_q, rundf_q;
  logic          rd_ok;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) sync_q <= '0;
    else         sync_q <= {sync_q[SYNC_STAGES-2:0], rif.wptr_g};
  end

  assign wq_g = sync_q[SYNC_STAGES-1];

  for (genvar i = 0; i < PW; i++) begin : g_g2b
    assign wq_b[i] = ^wq_g[PW-1:i];
  end

  // Reads are gated by the registered empty flag, so a stale pointer only
  // ever delays a read, never lets one through early.
  assign rd_ok      = rif.rinc && !rempty_q;
  assign rbin_next  = rbin + {{ADDR_W{1'b0}}, rd_ok};
  assign rgray_next = (rbin_next >> 1) ^ rbin_next;
  assign cnt_next   = wq_b - rbin_next;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin      <= '0;
      rgray     <= '0;
      rcount_q  <= '0;
      rempty_q  <= 1'b1;
      raempty_q <= 1'b1;
      rundf_q   <= 1'b0;
    end else begin
      rbin      <= rbin_next;
      rgray     <= rgray_next;
      rcount_q  <= cnt_next;
      rempty_q  <= (rgray_next == wq_g);
      raempty_q <= (cnt_next <= AE_TH);
      rundf_q   <= rundf_q | (rif.rinc & rempty_q);
    end
  end

  assign rif.raddr     = rbin[ADDR_W-1:0];
  assign rif.rptr_g    = rgray;
  assign rif.rq_wptr_b = wq_b;
  assign rif.rcount    = rcount_q;
  assign rif.rempty    = rempty_q;
  assign rif.raempty   = raempty_q;
  assign rif.rundf     = rundf_q;
endmodule

// File: tb/tb_rd_ptr_sync_ctrl.sv
// Directed bench: default-param table walk plus an ADDR_W=2/SYNC_STAGES=3 wrap run.
module tb_rd_ptr_sync_ctrl;
  logic rclk = 1'b0;
  logic rrst_n = 1'b0;
  int checks = 0;
  int failures = 0;

  always #5 rclk = ~rclk;

  rd_ptr_sync_if #(.ADDR_W(10)) ifa ();
  rd_ptr_sync_if #(.ADDR_W(2))  ifb ();

  rd_ptr_sync_ctrl #(.ADDR_W(10), .SYNC_STAGES(2), .AEMPTY_TH(4)) dut_a (
    .rclk(rclk), .rrst_n(rrst_n), .rif(ifa.slave));
  rd_ptr_sync_ctrl #(.ADDR_W(2), .SYNC_STAGES(3), .AEMPTY_TH(4)) dut_b (
    .rclk(rclk), .rrst_n(rrst_n), .rif(ifb.slave));

  typedef struct {
    logic [10:0] w;
    logic        ri;
    logic [9:0]  ad;
    logic [10:0] pg, qb, cnt;
    logic        e, ae, u;
  } vec_t;

  vec_t tbl[18];

  function automatic vec_t mk(int w, int ri, int ad, int pg, int qb, int cnt,
                              int e, int ae, int u);
    vec_t v;
    v.w = 11'(w); v.ri = ri[0]; v.ad = 10'(ad); v.pg = 11'(pg); v.qb = 11'(qb);
    v.cnt = 11'(cnt); v.e = e[0]; v.ae = ae[0]; v.u = u[0];
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endtask

  task automatic chk_rst_a(input string p);
    chk({p, ".raddr"},   32'(ifa.raddr), 0);
    chk({p, ".rptr_g"},  32'(ifa.rptr_g), 0);
    chk({p, ".rq"},      32'(ifa.rq_wptr_b), 0);
    chk({p, ".rcount"},  32'(ifa.rcount), 0);
    chk({p, ".rempty"},  32'(ifa.rempty), 1);
    chk({p, ".raempty"}, 32'(ifa.raempty), 1);
    chk({p, ".rundf"},   32'(ifa.rundf), 0);
  endtask

  initial begin
    int wb, rb, writes, reads, wraps, cyc, n;
    logic [2:0] prevg, wb3;

    // wptr 0->1->3->2, drain 3, underflow, then jump to binary 10 and drain
    tbl[0]  = mk(1,  0, 0, 0,  0,  0, 1, 1, 0);
    tbl[1]  = mk(3,  0, 0, 0,  1,  0, 1, 1, 0);
    tbl[2]  = mk(2,  0, 0, 0,  2,  1, 0, 1, 0);
    tbl[3]  = mk(2,  0, 0, 0,  3,  2, 0, 1, 0);
    tbl[4]  = mk(2,  0, 0, 0,  3,  3, 0, 1, 0);
    tbl[5]  = mk(2,  1, 1, 1,  3,  2, 0, 1, 0);
    tbl[6]  = mk(2,  1, 2, 3,  3,  1, 0, 1, 0);
    tbl[7]  = mk(2,  1, 3, 2,  3,  0, 1, 1, 0);
    tbl[8]  = mk(2,  1, 3, 2,  3,  0, 1, 1, 1);
    tbl[9]  = mk(2,  0, 3, 2,  3,  0, 1, 1, 1);
    tbl[10] = mk(15, 0, 3, 2,  3,  0, 1, 1, 1);
    tbl[11] = mk(15, 0, 3, 2,  10, 0, 1, 1, 1);
    tbl[12] = mk(15, 0, 3, 2,  10, 7, 0, 0, 1);
    tbl[13] = mk(15, 1, 4, 6,  10, 6, 0, 0, 1);
    tbl[14] = mk(15, 1, 5, 7,  10, 5, 0, 0, 1);
    tbl[15] = mk(15, 1, 6, 5,  10, 4, 0, 1, 1);
    tbl[16] = mk(15, 1, 7, 4,  10, 3, 0, 1, 1);
    tbl[17] = mk(15, 1, 8, 12, 10, 2, 0, 1, 1);

    ifa.wptr_g = '0; ifa.rinc = 1'b0;
    ifb.wptr_g = '0; ifb.rinc = 1'b0;
    #12;
    chk_rst_a("rst");
    @(negedge rclk);
    rrst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      ifa.wptr_g = tbl[i].w;
      ifa.rinc   = tbl[i].ri;
      @(posedge rclk); #1;
      chk($sformatf("v%0d.raddr", i),   32'(ifa.raddr),     32'(tbl[i].ad));
      chk($sformatf("v%0d.rptr_g", i),  32'(ifa.rptr_g),    32'(tbl[i].pg));
      chk($sformatf("v%0d.rq", i),      32'(ifa.rq_wptr_b), 32'(tbl[i].qb));
      chk($sformatf("v%0d.rcount", i),  32'(ifa.rcount),    32'(tbl[i].cnt));
      chk($sformatf("v%0d.rempty", i),  32'(ifa.rempty),    32'(tbl[i].e));
      chk($sformatf("v%0d.raempty", i), 32'(ifa.raempty),   32'(tbl[i].ae));
      chk($sformatf("v%0d.rundf", i),   32'(ifa.rundf),     32'(tbl[i].u));
      if (i == 9) begin
        for (int k = 0; k < 10; k++) begin
          @(posedge rclk); #1;
          chk("idle.rundf", 32'(ifa.rundf), 1);
          chk("idle.raddr", 32'(ifa.raddr), 3);
        end
      end
    end

    // Asynchronous reset mid-drain (rcount=2), checked before the next edge.
    ifa.rinc = 1'b0;
    #2 rrst_n = 1'b0;
    #1 chk_rst_a("midrst");
    ifa.wptr_g = '0;
    @(negedge rclk);
    rrst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge rclk); #1;
      chk("post_rst.rempty", 32'(ifa.rempty), 1);
      chk("post_rst.rcount", 32'(ifa.rcount), 0);
    end

    // DUT B: flag latency of SYNC_STAGES+1 edges for the first write.
    ifb.wptr_g = 3'd1;
    n = 0;
    while (n < 10) begin
      @(posedge rclk); #1;
      n++;
      if (!ifb.rempty) break;
    end
    chk("b.flag_lat", 32'(n), 4);
    chk("b.rcount_first", 32'(ifb.rcount), 1);
    chk("b.rq_first", 32'(ifb.rq_wptr_b), 1);

    // 20 writes / 20 reads interleaved, both pointers wrap.
    wb = 1; rb = 0; writes = 1; reads = 0; wraps = 0; cyc = 0;
    prevg = ifb.rptr_g;
    while ((writes < 20 || reads < 20) && cyc < 400) begin
      ifb.rinc = !ifb.rempty && reads < 20;
      if (writes < 20 && wb - rb < 4) begin wb++; writes++; end
      wb3 = 3'(wb);
      ifb.wptr_g = wb3 ^ (wb3 >> 1);
      @(posedge rclk); #1;
      cyc++;
      if (ifb.rinc) begin rb++; reads++; end
      chk("b.raddr", 32'(ifb.raddr), 32'(rb % 4));
      chk("b.cnt_le_true", 32'(int'(ifb.rcount) <= wb - rb), 1);
      chk("b.cnt_le4", 32'(ifb.rcount <= 3'd4), 1);
      chk("b.gray1", 32'($countones(prevg ^ ifb.rptr_g) <= 1), 1);
      if (prevg == 3'b100 && ifb.rptr_g == 3'b000) wraps++;
      prevg = ifb.rptr_g;
    end
    chk("b.done", 32'(writes == 20 && reads == 20), 1);
    ifb.rinc = 1'b0;
    repeat (6) @(posedge rclk);
    #1;
    chk("b.end_rempty", 32'(ifb.rempty), 1);
    chk("b.end_rcount", 32'(ifb.rcount), 0);
    chk("b.end_rundf", 32'(ifb.rundf), 0);
    chk("b.wraps", 32'(wraps), 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rd_ptr_sync_ctrl.md
RD_PTR_SYNC_CTRL -- requirements
Module: rd_ptr_sync_ctrl

Interface
REQ-001 Parameter ADDR_W, default 10: FIFO address width; pointers are ADDR_W+1 bits, including the wrap bit.
REQ-002 Parameter SYNC_STAGES, default 2, legal range 2..4: number of flops in the write-pointer synchronizer.
REQ-003 Parameter AEMPTY_TH, default 4: almost-empty threshold, in entries.
REQ-004 rclk  input  1  read-domain clock.
REQ-005 rrst_n  input  1  reset, asynchronous, active-low.
REQ-006 wptr_g  input  ADDR_W+1  Gray-coded write pointer from the write domain; asynchronous to rclk.
REQ-007 rinc  input  1  read request for the current rclk cycle.
REQ-008 raddr  output  ADDR_W  RAM read address, equal to the binary read pointer LSBs.
REQ-009 rptr_g  output  ADDR_W+1  registered Gray read pointer, sent to the write domain.
REQ-010 rq_wptr_b  output  ADDR_W+1  synchronized write pointer, converted to binary.
REQ-011 rcount  output  ADDR_W+1  registered fill level seen by the read side.
REQ-012 rempty  output  1  registered empty flag.
REQ-013 raempty  output  1  registered almost-empty flag.
REQ-014 rundf  output  1  sticky underflow flag.

Function
REQ-015 Synchronizer SHALL be a chain of SYNC_STAGES registers clocked by rclk, with no logic between stages; the chain input is wptr_g.
REQ-016 The last chain stage SHALL be converted Gray->binary combinationally, using b[i] = XOR of g[ADDR_W:i]; the result drives rq_wptr_b.
REQ-017 The internal binary read pointer rbin SHALL hold a read-valid state.
- rd_ok = rinc && !rempty.
- rbin_next = rbin + rd_ok, modulo 2^(ADDR_W+1).
- rgray_next = (rbin_next >> 1) ^ rbin_next.
REQ-018 rbin and rptr_g SHALL update to rbin_next and rgray_next on every rclk rising edge; raddr = rbin[ADDR_W-1:0].
REQ-019 rempty SHALL register (rgray_next == last sync stage) on every edge; rcount SHALL register (rq_wptr_b - rbin_next) modulo 2^(ADDR_W+1).
REQ-020 raempty SHALL register ((rq_wptr_b - rbin_next) <= AEMPTY_TH).
REQ-021 Latency: a stable wptr_g change SHALL appear in rq_wptr_b after SYNC_STAGES rclk edges, and in rempty/rcount/raempty on edge SYNC_STAGES+1.
REQ-022 A read SHALL be reflected in raddr, rptr_g and the flags on the same edge that accepts it (zero added latency).
- When the last entry is read, rempty asserts on that edge.
REQ-023 Underflow: rinc while rempty is high SHALL leave rbin unchanged and SHALL set rundf to 1, which holds until reset.
REQ-024 Wrap-around: when rbin goes from 2^(ADDR_W+1)-1 to 0, raddr wraps to 0.
- rcount stays correct across any wrap of either pointer.
REQ-025 Simultaneous read and write-pointer advance in one cycle SHALL yield rcount = previous count + (write delta) - 1, with no glitch on rempty.
REQ-026 rempty SHALL be conservative: it never deasserts before the synchronized write pointer shows the data.
- A stale pointer may hold rempty high longer, which is acceptable.
REQ-027 Only rptr_g SHALL cross to the write domain; it SHALL come directly from a register.
- At most one bit of rptr_g changes per edge.

Reset
REQ-028 rrst_n low SHALL asynchronously clear every register.
- Outputs: all sync stages, rbin, rptr_g, raddr, rq_wptr_b, rcount and rundf = 0; rempty = 1; raempty = 1.
REQ-029 Reset deassertion SHALL be synchronized to rclk by the integrating block; this block adds no reset synchronizer.
REQ-030 Reset asserted mid-operation SHALL return all outputs to their REQ-028 values immediately, without waiting for rclk.
- All in-flight synchronizer contents are discarded.

Verification
REQ-031 Reset, default params, wptr_g=0 -> rempty=1, raempty=1, rcount=0, raddr=0, rptr_g=0, rundf=0.
REQ-032 After reset, wptr_g stepped 0->1->3->2 (gray of 3) one value per cycle, then held -> rempty drops on edge 3 after gray 2 is stable; rcount=3, raempty=1, rq_wptr_b=3.
REQ-033 From REQ-032, rinc=1 for 3 cycles -> raddr 1,2,3; rptr_g 1,3,2; rcount 2,1,0; rempty=1 on the third accepting edge; rundf stays 0.
REQ-034 rinc=1 with rempty=1 -> raddr unchanged and rundf=1; rundf still 1 after 10 idle cycles; cleared only by rrst_n.
REQ-035 ADDR_W=2, SYNC_STAGES=3: run 20 writes and 20 reads interleaved -> rbin wraps 7->0 twice and rcount never exceeds 4; flag latency is 4 edges; Gray single-bit property holds on rptr_g.
REQ-036 Assert rrst_n low mid-drain (rcount=2) -> all outputs take reset values before the next rclk edge; after release and wptr_g=0, rempty remains 1.
